// File: rtl/rom_arbiter.sv
// Two-port read arbiter in front of a registered-output ROM.
// Port A (CPU fetch) and port B (loader/debug) share one ROM. At most one
// ROM transaction is in flight: IDLE -> ISSUE -> WAIT -> RESP.
// Ties are resolved round-robin by default. Define ROM_ARB_FIXED_PRIO_EN to
// give port A fixed priority; the last-granted pointer is then removed.
module rom_arbiter (
  input  logic        clk,
  input  logic        reset,
  // Port A (CPU fetch)
  input  logic        a_req,
  input  logic [11:0] a_adr,
  output logic        a_gnt,
  output logic        a_valid,
  output logic [15:0] a_data,
  // Port B (loader / debug)
  input  logic        b_req,
  input  logic [11:0] b_adr,
  output logic        b_gnt,
  output logic        b_valid,
  output logic [15:0] b_data,
  // ROM side
  output logic        rom_ce,
  output logic        rom_oe,
  output logic [11:0] rom_adr,
  input  logic [15:0] rom_data
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;  // 0: port A, 1: port B
  logic [11:0] adr_q, adr_d;
  logic [15:0] a_data_q, a_data_d;
  logic [15:0] b_data_q, b_data_d;
  logic        grant_a;

`ifdef ROM_ARB_FIXED_PRIO_EN
  // Port A wins whenever it requests.
  assign grant_a = a_req;
`else
  logic last_b_q, last_b_d;  // 1: port B was granted last

  // A wins if alone, or on a tie when B had the last grant.
  assign grant_a = a_req & (~b_req | last_b_q);

  // Pointer follows every grant; reset favours A on the first tie.
  always_comb begin
    last_b_d = last_b_q;
    if (state_q == StIdle && (a_req || b_req)) begin
      last_b_d = ~grant_a;
    end
  end

  // Last-granted pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end
`endif

  // Next-state, owner/address latch and data capture.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    adr_d    = adr_q;
    a_data_d = a_data_q;
    b_data_d = b_data_q;
    unique case (state_q)
      StIdle: begin
        if (a_req || b_req) begin
          owner_d = ~grant_a;
          adr_d   = grant_a ? a_adr : b_adr;
          state_d = StIssue;
        end
      end
      StIssue: begin
        state_d = StWait;
      end
      StWait: begin
        // ROM output is valid this cycle; only the owner's register changes.
        if (owner_q) begin
          b_data_d = rom_data;
        end else begin
          a_data_d = rom_data;
        end
        state_d = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      adr_q    <= '0;
      a_data_q <= '0;
      b_data_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      adr_q    <= adr_d;
      a_data_q <= a_data_d;
      b_data_q <= b_data_d;
    end
  end

  // Pulses are decoded from state, so reset clears them immediately.
  assign a_gnt   = (state_q == StIssue) && !owner_q;
  assign b_gnt   = (state_q == StIssue) &&  owner_q;
  assign a_valid = (state_q == StResp)  && !owner_q;
  assign b_valid = (state_q == StResp)  &&  owner_q;
  assign rom_ce  = (state_q == StIssue);
  assign rom_oe  = (state_q == StIssue);
  // Address register only changes on a grant, so it holds outside ISSUE.
  assign rom_adr = adr_q;
  assign a_data  = a_data_q;
  assign b_data  = b_data_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter. Stimulus pushes expected grants and
// responses into queues; negedge monitors pop and compare.
// Honours ROM_ARB_FIXED_PRIO_EN for the tie-breaking expectations.
module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_req = 1'b0, b_req = 1'b0;
  logic [11:0] a_adr = '0, b_adr = '0;
  logic        a_gnt, a_valid, b_gnt, b_valid;
  logic [15:0] a_data, b_data;
  logic        rom_ce, rom_oe;
  logic [11:0] rom_adr;
  logic [15:0] rom_data = '0;

  rom_arbiter dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_adr(a_adr), .a_gnt(a_gnt), .a_valid(a_valid), .a_data(a_data),
    .b_req(b_req), .b_adr(b_adr), .b_gnt(b_gnt), .b_valid(b_valid), .b_data(b_data),
    .rom_ce(rom_ce), .rom_oe(rom_oe), .rom_adr(rom_adr), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  // ROM contents: word 5 is 0x1234, otherwise {adr[7:0]^0xC3, adr[7:0]}.
  function automatic logic [15:0] rom_word(input logic [11:0] adr);
    if (adr == 12'h005) return 16'h1234;
    return {adr[7:0] ^ 8'hC3, adr[7:0]};
  endfunction

  // Registered-output ROM model.
  always @(posedge clk) if (rom_ce && rom_oe) rom_data <= rom_word(rom_adr);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          port;  // 0: A, 1: B
    logic [11:0] adr;
    logic [15:0] data;
    int          gap;   // required cycles since previous grant, 0 = unchecked
  } txn_t;

  txn_t gnt_q[$];
  txn_t rsp_q[$];
  logic [15:0] exp_a_data = '0, exp_b_data = '0;
  int last_gnt_cyc = 0;

  // Monitor: grants, responses, ROM strobes and data hold.
  always @(negedge clk) begin
    txn_t e;
    if (reset) begin
      exp_a_data = '0;
      exp_b_data = '0;
    end else begin
      if (a_gnt && b_gnt) chk("gnt_both", 1, 0);
      if (a_valid && b_valid) chk("valid_both", 1, 0);
      if (a_gnt || b_gnt) begin
        if (gnt_q.size() == 0) begin
          chk("gnt_unexpected", {31'd0, b_gnt}, 32'hFFFF_FFFF);
        end else begin
          e = gnt_q.pop_front();
          chk("gnt_port", {31'd0, b_gnt}, {31'd0, e.port});
          chk("issue_ce_oe", {30'd0, rom_ce, rom_oe}, 32'd3);
          chk("issue_adr", {20'd0, rom_adr}, {20'd0, e.adr});
          if (e.gap != 0) chk("gnt_spacing", cyc - last_gnt_cyc, e.gap);
        end
        last_gnt_cyc = cyc;
      end else begin
        chk("idle_ce_oe", {30'd0, rom_ce, rom_oe}, 32'd0);
      end
      if (a_valid || b_valid) begin
        if (rsp_q.size() == 0) begin
          chk("valid_unexpected", {31'd0, b_valid}, 32'hFFFF_FFFF);
        end else begin
          e = rsp_q.pop_front();
          chk("valid_port", {31'd0, b_valid}, {31'd0, e.port});
          chk("valid_latency", cyc - last_gnt_cyc, 2);
          if (e.port) exp_b_data = e.data;
          else        exp_a_data = e.data;
          chk("a_data", {16'd0, a_data}, {16'd0, exp_a_data});
          chk("b_data", {16'd0, b_data}, {16'd0, exp_b_data});
        end
      end
    end
  end

  task automatic expect_txn(input bit port, input logic [11:0] adr, input logic [15:0] data,
                            input int gap);
    txn_t e;
    e.port = port; e.adr = adr; e.data = data; e.gap = gap;
    gnt_q.push_back(e);
    rsp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt_valid"}, {28'd0, a_gnt, b_gnt, a_valid, b_valid}, 32'd0);
    chk({tag, "_ce_oe"}, {30'd0, rom_ce, rom_oe}, 32'd0);
    chk({tag, "_rom_adr"}, {20'd0, rom_adr}, 32'd0);
    chk({tag, "_data"}, {a_data, b_data}, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; a_req = 1'b0; b_req = 1'b0;
    #1 check_reset_outputs("reset");
    gnt_q.delete();
    rsp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Bounded wait for a grant on the given port, sampled at negedge.
  task automatic wait_gnt(input bit port);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (port ? b_gnt : a_gnt) return;
    end
    chk("gnt_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (gnt_q.size() == 0 && rsp_q.size() == 0) break;
      @(posedge clk);
    end
    chk("drain", gnt_q.size() + rsp_q.size(), 0);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    // Reset state.
    #2 check_reset_outputs("por");
    do_reset();

    // Single A read of word 5.
    expect_txn(1'b0, 12'h005, 16'h1234, 0);
    a_adr = 12'h005; a_req = 1'b1;
    wait_gnt(1'b0);
    @(posedge clk); #1 a_req = 1'b0;
    drain();

    // Both ports requesting continuously.
    do_reset();
`ifdef ROM_ARB_FIXED_PRIO_EN
    expect_txn(1'b0, 12'h010, 16'hD310, 0);
    expect_txn(1'b0, 12'h010, 16'hD310, 4);
    expect_txn(1'b0, 12'h010, 16'hD310, 4);
    expect_txn(1'b0, 12'h010, 16'hD310, 4);
`else
    expect_txn(1'b0, 12'h010, 16'hD310, 0);
    expect_txn(1'b1, 12'h020, 16'hE320, 4);
    expect_txn(1'b0, 12'h010, 16'hD310, 4);
    expect_txn(1'b1, 12'h020, 16'hE320, 4);
`endif
    a_adr = 12'h010; b_adr = 12'h020; a_req = 1'b1; b_req = 1'b1;
    begin
      int n = 0;
      for (int i = 0; i < 40 && n < 4; i++) begin
        @(negedge clk);
        if (a_gnt || b_gnt) n++;
      end
      chk("tie_grants", n, 4);
    end
    @(posedge clk); #1 a_req = 1'b0; b_req = 1'b0;
    drain();

    // Reset during WAIT of a B read: no response, data cleared.
    do_reset();
    begin
      txn_t e;
      e.port = 1'b1; e.adr = 12'h030; e.data = 16'hF330; e.gap = 0;
      gnt_q.push_back(e);
    end
    b_adr = 12'h030; b_req = 1'b1;
    wait_gnt(1'b1);
    @(posedge clk); #1 b_req = 1'b0; reset = 1'b1;
    #1 check_reset_outputs("mid_wait");
    @(posedge clk); #1 reset = 1'b0;
    repeat (8) @(posedge clk);
    #1 chk("post_reset_b_data", {16'd0, b_data}, 32'd0);
    chk("post_reset_queues", gnt_q.size() + rsp_q.size(), 0);

    // B requests during A's ISSUE; A data must survive B's read.
    do_reset();
    expect_txn(1'b0, 12'h007, 16'hC407, 0);
    expect_txn(1'b1, 12'h041, 16'h8241, 4);
    a_adr = 12'h007; a_req = 1'b1;
    wait_gnt(1'b0);
    a_req = 1'b0; b_adr = 12'h041; b_req = 1'b1;
    wait_gnt(1'b1);
    @(posedge clk); #1 b_req = 1'b0;
    drain();

    // Sequential sweep of A addresses 0x000..0x00F.
    do_reset();
    a_adr = 12'h000; a_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      expect_txn(1'b0, 12'(i), rom_word(12'(i)), (i == 0) ? 0 : 4);
      wait_gnt(1'b0);
      @(posedge clk); #1;
      if (i < 15) a_adr = 12'(i + 1);
      else        a_req = 1'b0;
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 a_req  in  1  port A (CPU fetch) read request; held high with a_adr stable until a_gnt.
REQ-004 a_adr  in  12  port A word address.
REQ-005 a_gnt  out  1  one-cycle pulse: port A request accepted.
REQ-006 a_valid  out  1  one-cycle pulse: a_data holds the port A result.
REQ-007 a_data  out  16  port A read data; held until the next port A response.
REQ-008 b_req, b_adr, b_gnt, b_valid, b_data: port B (loader/debug), same widths and rules as REQ-003..REQ-007.
REQ-009 rom_ce  out  1  ROM chip enable, active-high.
REQ-010 rom_oe  out  1  ROM output enable, active-high.
REQ-011 rom_adr  out  12  ROM address (PCadr).
REQ-012 rom_data  in  16  ROM instruction output; registered in ROM, valid one cycle after rom_ce=rom_oe=1 with rom_adr.

Function
REQ-013 FSM states IDLE, ISSUE, WAIT, RESP; one ROM transaction in flight at most.
REQ-014 IDLE: on edge with a_req|b_req, arbitrate, latch winner address and owner, pulse owner gnt next cycle, go ISSUE; otherwise stay IDLE.
REQ-015 ISSUE (1 cycle): rom_ce=rom_oe=1, rom_adr=latched address; go WAIT.
REQ-016 WAIT (1 cycle): rom_ce=rom_oe=0; at end of cycle capture rom_data into owner data register; go RESP.
REQ-017 RESP (1 cycle): owner valid=1; go IDLE.
REQ-018 Latency: req sampled at edge E0 -> gnt high cycle after E0 -> valid high 3 cycles after E0; max throughput one transaction per 4 cycles.
REQ-019 rom_ce, rom_oe low and rom_adr held at last value outside ISSUE.
REQ-020 gnt and valid pulses exactly one cycle; never to both ports in the same cycle.
REQ-021 Request still high in the cycle after gnt is treated as a new request at the next IDLE.
REQ-022 Non-owner data register unchanged during a transaction.
REQ-023 Round-robin: single requester always wins; both requesting -> port not granted last wins; pointer updates on each grant.
REQ-024 Request asserted or dropped while FSM is not IDLE is ignored until IDLE; no queuing.

Reset
REQ-025 reset asserted: FSM=IDLE, all gnt/valid=0, rom_ce=rom_oe=0, rom_adr=0, a_data=b_data=0, last-granted pointer=B (so A wins first tie).
REQ-026 reset mid-transaction: transaction dropped, no valid pulse after reset release.
REQ-027 First arbitration occurs at the first clk edge after reset deasserts.

Configuration
REQ-028 Macro ROM_ARB_FIXED_PRIO_EN: defined -> port A always wins ties (pointer unused); undefined -> round-robin per REQ-023.

Verification
REQ-029 a_req=1, a_adr=0x005, ROM word5=0x1234 -> a_gnt cycle 1, rom_ce=rom_oe=1 with rom_adr=0x005 cycle 1, a_valid cycle 3 with a_data=0x1234.
REQ-030 a_req and b_req high continuously (a_adr=0x010, b_adr=0x020), round-robin -> grants alternate A,B,A,B every 4 cycles; b_data=ROM[0x020].
REQ-031 Same as REQ-030 with ROM_ARB_FIXED_PRIO_EN -> only port A granted while a_req held; b_gnt never pulses.
REQ-032 Reset asserted during WAIT of a port B read -> outputs zero immediately; no b_valid after release; b_data=0.
REQ-033 b_req asserted during ISSUE of a port A read -> b_gnt one cycle after A's RESP-to-IDLE edge; a_data unchanged by B transaction.
REQ-034 Sweep a_adr 0x000..0x00F sequentially -> sixteen a_valid pulses, a_data matches ROM contents each, 4 cycles apart.
